button_ctrl: RTL

BUTTON_CTRL -- requirements
Module: button_ctrl

---
 rtl/button_ctrl_pkg.sv | 18 +
 rtl/button_ctrl_if.sv | 21 ++
 rtl/button_debounce.sv | 52 +++++
 rtl/button_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/button_ctrl_pkg.sv
// Shared types for the button controller: per-button FSM state and button indices.
package common;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_RELEASE
    } btn_state_t;

    localparam int NBTN      = 2;
    localparam int BTN_MAGIC = 0;
    localparam int BTN_PAUSE = 1;

    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/button_ctrl_if.sv
// Button/magic-controller signal bundle; master drives buttons and ack, slave raises requests.
interface button_ctrl_if;

    logic n_btn_magic;
    logic n_btn_pause;
    logic magic_mode;
    logic magic_button;
    logic pause_button;
    logic reboot_req;

    modport master (
        output n_btn_magic, n_btn_pause, magic_mode,
        input  magic_button, pause_button, reboot_req
    );

    modport slave (
        input  n_btn_magic, n_btn_pause, magic_mode,
        output magic_button, pause_button, reboot_req
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a 1 ms tick debouncer; output idles released (1).
module button_debounce
    import common::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic tick_1ms,
    input  logic n_raw,
    output logic n_stable
);

    localparam int CW = cnt_width(DEBOUNCE_MS);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (tick_1ms) begin
            if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
                stable_d = s2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            s1_q     <= n_raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign n_stable = stable_q;

endmodule

// File: rtl/button_ctrl.sv
// Magic/pause button request controller with shared 1 ms prescaler.
// Optional long-press reboot request enabled by BUTTON_LONGPRESS_EN.
module button_ctrl
    import common::*;
#(
    parameter int CLK_HZ         = 28000000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int REQ_TIMEOUT_MS = 100,
    parameter int LONG_MS        = 2000
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic n_btn_magic,
    input  logic n_btn_pause,
    input  logic magic_mode,
    output logic magic_button,
    output logic pause_button,
    output logic reboot_req
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int PW  = cnt_width(DIV - 1);
    localparam int TW  = cnt_width(REQ_TIMEOUT_MS);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    logic [NBTN-1:0] n_raw;
    logic [NBTN-1:0] n_stb;
    logic [NBTN-1:0] n_prev_q;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
    logic [NBTN-1:0] req;

    btn_state_t    st_q  [NBTN];
    btn_state_t    st_d  [NBTN];
    logic [TW-1:0] tmr_q [NBTN];
    logic [TW-1:0] tmr_d [NBTN];

    assign tick  = (pre_q == PW'(DIV - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    assign n_raw[BTN_MAGIC] = n_btn_magic;
    assign n_raw[BTN_PAUSE] = n_btn_pause;

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_deb
        button_debounce #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_deb (
            .clk28   (clk28),
            .rst_n   (rst_n),
            .tick_1ms(tick),
            .n_raw   (n_raw[gi]),
            .n_stable(n_stb[gi])
        );
    end

    assign press = n_prev_q & ~n_stb;
    assign rel   = ~n_prev_q & n_stb;

    // Request is asserted combinationally so it rises on the press edge itself
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            st_d[i]  = st_q[i];
            tmr_d[i] = tmr_q[i];
            req[i]   = 1'b0;
            unique case (st_q[i])
                IDLE: begin
                    if (press[i]) begin
                        req[i]   = 1'b1;
                        st_d[i]  = REQUEST;
                        tmr_d[i] = '0;
                    end
                end
                REQUEST: begin
                    if (magic_mode ||
                        (tick && tmr_q[i] == TW'(REQ_TIMEOUT_MS - 1))) begin
                        st_d[i] = WAIT_RELEASE;
                    end else begin
                        req[i] = 1'b1;
                        if (tick) tmr_d[i] = tmr_q[i] + 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (rel[i]) st_d[i] = IDLE;
                end
                default: st_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            n_prev_q <= '1;
            for (int i = 0; i < NBTN; i++) begin
                st_q[i]  <= IDLE;
                tmr_q[i] <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            n_prev_q <= n_stb;
            for (int i = 0; i < NBTN; i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
            end
        end
    end

    assign magic_button = req[BTN_MAGIC];
    assign pause_button = req[BTN_PAUSE];

`ifdef BUTTON_LONGPRESS_EN
    localparam int LW = cnt_width(LONG_MS);

    logic [LW-1:0] lp_q, lp_d;
    logic          rb_q, rb_d;

    // Counter saturates at LONG_MS so the pulse fires once per press
    always_comb begin
        lp_d = lp_q;
        rb_d = 1'b0;
        if (n_stb[BTN_MAGIC]) begin
            lp_d = '0;
        end else if (tick && lp_q != LW'(LONG_MS)) begin
            lp_d = lp_q + 1'b1;
            rb_d = (lp_q == LW'(LONG_MS - 1));
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            lp_q <= '0;
            rb_q <= 1'b0;
        end else begin
            lp_q <= lp_d;
            rb_q <= rb_d;
        end
    end

    assign reboot_req = rb_q;
`else
    assign reboot_req = 1'b0;
`endif

endmodule
